// File: rtl/mmio_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mmio_uart_pkg
// Brief   : Shared types and register map for the memory-mapped UART TX.
// Revision: 1.0
// ============================================================================
package mmio_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIVL   = 2'd2;
    localparam logic [1:0] UART_DIVH   = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    // A zero divisor would stall the bit counter, so it runs at one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO; a push into a full FIFO succeeds if a pop
//           happens in the same cycle.
// Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : mmio_uart_tx
// Brief   : Bus-mapped 8N1 UART transmitter with TX FIFO and divisor register.
// Revision: 1.0
// ============================================================================
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rW,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        sel,
    output logic        txd,
    output logic        tx_idle
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    offset;
    logic          wr_stb;
    logic          push_req;
    logic          push_ok;
    logic          fifo_pop;
    logic [7:0]    fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic [4:0]    cnt_ext;
    logic [3:0]    count_sat;
    logic [7:0]    status;

    logic [15:0]   div_reg;
    logic          overflow;

    uart_state_t   state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [15:0]   bit_cnt, bit_cnt_n;
    logic [15:0]   frame_div, frame_div_n;
    logic          txd_n;
    logic          tx_idle_n;
    logic          bit_done;
    logic          load;

    assign sel      = (addr[15:2] == BASE_ADDR[15:2]);
    assign offset   = addr[1:0];
    assign wr_stb   = sel & ~rW;
    assign push_req = wr_stb & (offset == UART_DATA);
    assign push_ok  = push_req & (~fifo_full | fifo_pop);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (fifo_pop),
        .din   (wdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg  <= DEFAULT_DIV;
            overflow <= 1'b0;
        end else begin
            if (wr_stb) begin
                case (offset)
                    UART_DIVL:   div_reg[7:0]  <= wdata;
                    UART_DIVH:   div_reg[15:8] <= wdata;
                    UART_STATUS: overflow      <= 1'b0;
                    default:     ;
                endcase
            end
            if (push_req && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign cnt_ext   = 5'(fifo_count);
    assign count_sat = cnt_ext[4] ? 4'hF : cnt_ext[3:0];

    always_comb begin
        status                         = 8'h00;
        status[STAT_BUSY]              = (state != IDLE);
        status[STAT_FULL]              = fifo_full;
        status[STAT_EMPTY]             = fifo_empty;
        status[STAT_OVF]               = overflow;
        status[STAT_CNT_LSB +: 4]      = count_sat;
    end

    always_comb begin
        rdata = 8'h00;
        if (sel) begin
            case (offset)
                UART_STATUS: rdata = status;
                UART_DIVL:   rdata = div_reg[7:0];
                UART_DIVH:   rdata = div_reg[15:8];
                default:     rdata = 8'h00;
            endcase
        end
    end

    assign bit_done = (bit_cnt == 16'd0);

    always_comb begin
        state_n     = state;
        txd_n       = txd;
        shreg_n     = shreg;
        bit_idx_n   = bit_idx;
        bit_cnt_n   = bit_done ? (frame_div - 16'd1) : (bit_cnt - 16'd1);
        frame_div_n = frame_div;
        load        = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_n = bit_cnt;
                load      = ~fifo_empty;
            end
            START: begin
                if (bit_done) begin
                    state_n   = DATA;
                    txd_n     = shreg[0];
                    bit_idx_n = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = shreg >> 1;
                        txd_n     = shreg[1];
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
        endcase
        // Frame start: the divisor is sampled here so mid-frame writes wait.
        if (load) begin
            state_n     = START;
            txd_n       = 1'b0;
            shreg_n     = fifo_dout;
            bit_idx_n   = 3'd0;
            frame_div_n = eff_div(div_reg);
            bit_cnt_n   = eff_div(div_reg) - 16'd1;
        end
    end

    assign fifo_pop   = load;
    assign count_next = fifo_count + CW'(push_ok) - CW'(fifo_pop);
    assign tx_idle_n  = (state_n == IDLE) && (count_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            txd       <= 1'b1;
            tx_idle   <= 1'b1;
            shreg     <= 8'h00;
            bit_idx   <= 3'd0;
            bit_cnt   <= 16'd0;
            frame_div <= 16'd1;
        end else begin
            state     <= state_n;
            txd       <= txd_n;
            tx_idle   <= tx_idle_n;
            shreg     <= shreg_n;
            bit_idx   <= bit_idx_n;
            bit_cnt   <= bit_cnt_n;
            frame_div <= frame_div_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmio_uart_tx
// Brief   : Directed self-checking bench for mmio_uart_tx.
// Revision: 1.0
// ============================================================================
module tb_mmio_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic        rW;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        sel;
    logic        txd;
    logic        tx_idle;

    int total = 0;
    int bad   = 0;

    logic [7:0] rv;
    logic       sv;

    mmio_uart_tx dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .rW      (rW),
        .wdata   (wdata),
        .rdata   (rdata),
        .sel     (sel),
        .txd     (txd),
        .tx_idle (tx_idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        addr  = a;
        rW    = 1'b0;
        wdata = d;
        tick();
        rW    = 1'b1;
        addr  = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
        addr = a;
        rW   = 1'b1;
        #1;
        d    = rdata;
        s    = sel;
        addr = 16'h0000;
    endtask

    // Called one step after the edge where txd fell to the start bit.
    task automatic frame(input string tag, input logic [7:0] b, input int dv);
        logic [7:0] bb;
        logic       e;
        int         bn;
        bb = b;
        for (int i = 0; i < 10 * dv; i++) begin
            bn = i / dv;
            if (bn == 0)      e = 1'b0;
            else if (bn == 9) e = 1'b1;
            else              e = bb[bn-1];
            chk(tag, {15'd0, txd}, {15'd0, e});
            if (i == 0) chk({tag, "_busy"}, {15'd0, tx_idle}, 16'd0);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; addr = 16'h0000; rW = 1'b1; wdata = 8'h00;
        tick(); tick();
        rst = 1'b0;

        // reset state
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_idle", {15'd0, tx_idle}, 16'd1);
        rd(16'hD001, rv, sv); chk("rst_status", {8'd0, rv}, 16'h0004);
        rd(16'hD002, rv, sv); chk("rst_divl", {8'd0, rv}, 16'h0068);
        rd(16'hD003, rv, sv); chk("rst_divh", {8'd0, rv}, 16'h0000);

        // single frame 0x55 at div 4
        wr(16'hD002, 8'h04);
        wr(16'hD000, 8'h55);
        chk("w55_txd_hi", {15'd0, txd}, 16'd1);
        chk("w55_idle_lo", {15'd0, tx_idle}, 16'd0);
        rd(16'hD001, rv, sv); chk("w55_status", {8'd0, rv}, 16'h0010);
        tick();
        frame("f55", 8'h55, 4);
        chk("f55_idle", {15'd0, tx_idle}, 16'd1);
        chk("f55_txd", {15'd0, txd}, 16'd1);

        // div 2 readback and frame, then div 0
        wr(16'hD002, 8'h02);
        wr(16'hD003, 8'h00);
        rd(16'hD002, rv, sv); chk("div2_l", {8'd0, rv}, 16'h0002);
        rd(16'hD003, rv, sv); chk("div2_h", {8'd0, rv}, 16'h0000);
        wr(16'hD000, 8'hA3);
        tick();
        frame("fA3", 8'hA3, 2);
        chk("fA3_idle", {15'd0, tx_idle}, 16'd1);
        wr(16'hD002, 8'h00);
        rd(16'hD002, rv, sv); chk("div0_l", {8'd0, rv}, 16'h0000);
        wr(16'hD000, 8'h0F);
        tick();
        frame("f0F", 8'h0F, 1);
        chk("f0F_idle", {15'd0, tx_idle}, 16'd1);

        // fill FIFO at div 16, overflow and clear
        wr(16'hD002, 8'h10);
        for (int k = 0; k < 9; k++) wr(16'hD000, 8'h30 + 8'(k));
        rd(16'hD001, rv, sv); chk("full_status", {8'd0, rv}, 16'h0083);
        wr(16'hD000, 8'hEE);
        rd(16'hD001, rv, sv); chk("ovf_status", {8'd0, rv}, 16'h008B);
        wr(16'hD001, 8'h00);
        rd(16'hD001, rv, sv); chk("ovf_clear", {8'd0, rv}, 16'h0083);
        rst = 1'b1; tick(); rst = 1'b0;
        rd(16'hD001, rv, sv); chk("rst2_status", {8'd0, rv}, 16'h0004);
        rd(16'hD002, rv, sv); chk("rst2_divl", {8'd0, rv}, 16'h0068);
        chk("rst2_txd", {15'd0, txd}, 16'd1);

        // back-to-back frames, no idle gap
        wr(16'hD002, 8'h02);
        wr(16'hD000, 8'h81);
        wr(16'hD000, 8'h3C);
        frame("b2b_81", 8'h81, 2);
        frame("b2b_3C", 8'h3C, 2);
        chk("b2b_idle", {15'd0, tx_idle}, 16'd1);
        chk("b2b_txd", {15'd0, txd}, 16'd1);

        // reset during data bit 3
        wr(16'hD002, 8'h04);
        wr(16'hD000, 8'hF0);
        wr(16'hD000, 8'h12);
        repeat (17) tick();
        chk("mid_bit3", {15'd0, txd}, 16'd0);
        chk("mid_busy", {15'd0, tx_idle}, 16'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_txd", {15'd0, txd}, 16'd1);
        chk("mid_rst_idle", {15'd0, tx_idle}, 16'd1);
        rd(16'hD001, rv, sv); chk("mid_rst_status", {8'd0, rv}, 16'h0004);
        rst = 1'b0;
        tick();

        // address decode
        rd(16'hD004, rv, sv);
        chk("out_sel", {15'd0, sv}, 16'd0);
        chk("out_rdata", {8'd0, rv}, 16'h0000);
        rd(16'hD000, rv, sv);
        chk("data_rdata", {8'd0, rv}, 16'h0000);
        chk("data_sel", {15'd0, sv}, 16'd1);
        rd(16'hCFFF, rv, sv);
        chk("below_sel", {15'd0, sv}, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that sits on the CPU memory bus as a responder, alongside the test memory. The CPU writes bytes into a small transmit FIFO and reads status through a four-register window. A serializer drains the FIFO onto a single 8N1 serial line at a programmable bit rate. The top level ORs `rdata` into the read path whenever `sel` is high.

## Interface
- `BASE_ADDR`, default 16'hD000: window base; bits [1:0] must be 0.
- `FIFO_DEPTH`, default 8: number of transmit FIFO entries; power of 2, from 2 to 16.
- `DEFAULT_DIV`, default 16'd104: clocks per serial bit after reset.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `addr`, in, 16: CPU address, {memory_bus_h, memory_bus_l}.
- `rW`, in, 1: 1 = read, 0 = write.
- `wdata`, in, 8: CPU write data (xfer bus).
- `rdata`, out, 8: read data; combinational; 8'h00 when `sel` = 0.
- `sel`, out, 1: combinational; high when `addr[15:2]` == `BASE_ADDR[15:2]`.
- `txd`, out, 1: serial output, registered, idles high.
- `tx_idle`, out, 1: registered; high when FIFO empty and serializer in IDLE.

## Operation
- Register offsets (`addr[1:0]`):
  - 0 DATA: a write pushes `wdata` into the FIFO; a read returns 8'h00.
  - 1 STATUS (read): bit0 busy (serializer not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count (saturates at 15). A write of any value clears overflow.
  - 2 DIVL, 3 DIVH: read/write halves of a 16-bit divisor register.
- Write strobe: `sel & ~rW`, asserted for one clock. Each clock in which it holds counts as a separate write.
- Reads have no side effects.
- FIFO full:
  - A push is dropped and sets overflow.
  - If a pop happens in the same cycle, the push is accepted and overflow is not set.
- Serializer states: IDLE, START, DATA, STOP. Frame is 8N1, LSB first.
  - IDLE: when the FIFO is not empty, pop the head, latch the byte and latch the effective divisor (`div` = 0 is treated as 1), then go to START.
  - Each bit lasts `div` clocks, timed by a bit counter that reloads at every bit boundary.
  - START drives 0 → DATA drives bits 0..7 → STOP drives 1.
  - At the end of STOP: pop the next byte and go straight to START if the FIFO is not empty (no idle gap); otherwise go to IDLE.
- A divisor written mid-frame takes effect only at the next frame start.
- FIFO pointers wrap modulo `FIFO_DEPTH`. The count is held with one extra bit so that full and empty are distinguished.

## Timing
- Reset values:
  - `txd` = 1, `tx_idle` = 1.
  - FIFO empty, overflow = 0, state IDLE, divisor = `DEFAULT_DIV`.
- Reset mid-frame: at the next edge the frame is abandoned, `txd` = 1, and the FIFO is emptied.
- Latency: a DATA write captured at edge N makes the FIFO non-empty after N. At edge N+1 the byte is popped and `txd` falls to 0.
- Frame length: exactly 10×`div` clocks. `txd` changes only at bit boundaries.
- STATUS read the cycle after a push reflects the new count, because reads are combinational from registered state.
- `tx_idle` rises at the edge where STOP completes with the FIFO empty.

## Structure
- Package `mmio_uart_pkg`:
  - state enum `uart_state_t` (IDLE, START, DATA, STOP);
  - register offset constants `UART_DATA`, `UART_STATUS`, `UART_DIVL`, `UART_DIVH`;
  - STATUS bit-index constants.
- Sub-module `sync_fifo`: parameterised width and depth, push/pop/full/empty/count outputs, same-cycle push+pop allowed.
- Top module: address decode, register file, serializer FSM.

## Test plan
- Reset, then write 8'h55 to D000 with `div` = 4:
  - `txd` low at the edge after the write;
  - pattern 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks wide;
  - `tx_idle` high after 40 clocks.
- Write DIVL = 8'h02, DIVH = 8'h00:
  - read back 02/00;
  - next frame bits are 2 clocks wide;
  - `div` = 0 gives 1-clock bits.
- With `div` = 16, write 9 bytes back-to-back:
  - the first pops into the serializer, so the FIFO holds 8;
  - STATUS reads full = 1, count = 8, overflow = 0;
  - a 10th write sets overflow = 1;
  - a write to D001 clears it.
- Push two bytes: frames go out back-to-back with no idle cycle between the stop bit and the next start bit.
- Assert `rst` during DATA bit 3: next edge `txd` = 1, STATUS = 8'h04 (empty), `tx_idle` = 1.
- Read D004 (outside the window): `sel` = 0, `rdata` = 00. Read D000: `rdata` = 00, `sel` = 1.
